// File: rtl/alu_pipe.sv
// Registered ALU with iterative signed multiply; 1-cycle latency (DATA_W+1 for MUL/MULH).
// Result holds in DONE until out_ready_i; in_ready_o follows out_ready_i there for back-to-back ops.
module alu_pipe #(
    parameter int DATA_W = 32,
    parameter bit SAT_EN = 1'b0,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4:0]        alu_op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] alu_out_o,
    output logic              alu_overflow_o,
    output logic              alu_illegal_o,
    output logic              ovf_sticky_o,
    input  logic              clr_sticky_i
);
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOR  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b00110;
    localparam logic [4:0] OP_ROTR = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_NAND = 5'b01001;
    localparam logic [4:0] OP_MAX  = 5'b01010;
    localparam logic [4:0] OP_MIN  = 5'b01011;
    localparam logic [4:0] OP_ABS  = 5'b01100;
    localparam logic [4:0] OP_SLTS = 5'b01101;
    localparam logic [4:0] OP_SLL  = 5'b01110;
    localparam logic [4:0] OP_ROTL = 5'b01111;
    localparam logic [4:0] OP_ADDU = 5'b10000;
    localparam logic [4:0] OP_SRLU = 5'b10001;
    localparam logic [4:0] OP_MUL  = 5'b10010;
    localparam logic [4:0] OP_MULH = 5'b10011;

    localparam int CNT_W = $clog2(DATA_W);
    localparam int M     = DATA_W - 1;
    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              ovf;
        logic              ill;
    } res_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    res_t                res_q, res_d, alu_res, mul_res;
    logic                sticky_q, sticky_d;
    logic [2*DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum, prod;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d, hi_q, hi_d;

    logic                accept, is_mul, mul_last;
    logic [SH_W-1:0]     sh, nsh;
    logic [DATA_W:0]     addu;
    logic [DATA_W-1:0]   sum, diff, neg1, mag1, mag2, sat_val;
    logic                add_ovf, sub_ovf, slt;

    // Rotates use the complementary amount modulo DATA_W, so amount 0 collapses to src1.
    assign sh      = src2_i[SH_W-1:0];
    assign nsh     = ~sh + 1'b1;
    assign addu    = {1'b0, src1_i} + {1'b0, src2_i};
    assign sum     = addu[DATA_W-1:0];
    assign diff    = src1_i - src2_i;
    assign neg1    = ~src1_i + 1'b1;
    assign add_ovf = (src1_i[M] == src2_i[M]) && (sum[M] != src1_i[M]);
    assign sub_ovf = (src1_i[M] != src2_i[M]) && (diff[M] != src1_i[M]);
    assign slt     = $signed(src1_i) < $signed(src2_i);
    assign sat_val = src1_i[M] ? SMIN : SMAX;
    assign mag1    = src1_i[M] ? neg1 : src1_i;
    assign mag2    = src2_i[M] ? (~src2_i + 1'b1) : src2_i;
    assign is_mul  = (alu_op_i == OP_MUL) || (alu_op_i == OP_MULH);
    assign accept  = in_valid_i && in_ready_o;

    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            OP_ADD: begin
                alu_res.dat = (SAT_EN && add_ovf) ? sat_val : sum;
                alu_res.ovf = add_ovf;
            end
            OP_SUB: begin
                alu_res.dat = (SAT_EN && sub_ovf) ? sat_val : diff;
                alu_res.ovf = sub_ovf;
            end
            OP_AND:  alu_res.dat = src1_i & src2_i;
            OP_OR:   alu_res.dat = src1_i | src2_i;
            OP_XOR:  alu_res.dat = src1_i ^ src2_i;
            OP_NOR:  alu_res.dat = ~(src1_i | src2_i);
            OP_NOT:  alu_res.dat = ~src1_i;
            OP_NAND: alu_res.dat = ~(src1_i & src2_i);
            OP_SRA:  alu_res.dat = $unsigned($signed(src1_i) >>> sh);
            OP_SRLU: alu_res.dat = src1_i >> sh;
            OP_SLL:  alu_res.dat = src1_i << sh;
            OP_ROTR: alu_res.dat = (src1_i >> sh) | (src1_i << nsh);
            OP_ROTL: alu_res.dat = (src1_i << sh) | (src1_i >> nsh);
            OP_MAX:  alu_res.dat = slt ? src2_i : src1_i;
            OP_MIN:  alu_res.dat = slt ? src1_i : src2_i;
            OP_SLTS: alu_res.dat = {{(DATA_W-1){1'b0}}, slt};
            OP_ABS: begin
                alu_res.dat = src1_i[M] ? neg1 : src1_i;
                alu_res.ovf = (src1_i == SMIN);
            end
            OP_ADDU: begin
                alu_res.dat = sum;
                alu_res.ovf = addu[DATA_W];
            end
            OP_MUL, OP_MULH: alu_res = '0;
            default: alu_res.ill = 1'b1;
        endcase
    end

    // Final step and sign correction share one edge so DONE lands DATA_W cycles after accept.
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod     = neg_q ? (~acc_sum + 1'b1) : acc_sum;
    assign mul_last = (cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        mul_res     = '0;
        mul_res.dat = hi_q ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
        mul_res.ovf = !hi_q && (prod[2*DATA_W-1:DATA_W] != {DATA_W{prod[M]}});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = is_mul ? S_BUSY : S_DONE;
            S_BUSY: if (mul_last) state_d = S_DONE;
            S_DONE: begin
                if (out_ready_i) begin
                    if (accept) state_d = is_mul ? S_BUSY : S_DONE;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            S_IDLE: in_ready_o = 1'b1;
            S_DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        res_d    = res_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        if (accept) begin
            if (is_mul) begin
                acc_d    = '0;
                mcand_d  = {{DATA_W{1'b0}}, mag1};
                mplier_d = mag2;
                cnt_d    = '0;
                neg_d    = src1_i[M] ^ src2_i[M];
                hi_d     = (alu_op_i == OP_MULH);
            end else begin
                res_d = alu_res;
            end
        end else if (state_q == S_BUSY) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (mul_last) res_d = mul_res;
        end
    end

    // A set on the transfer cycle beats a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        if (out_valid_o && out_ready_i && res_q.ovf) sticky_d = 1'b1;
        else if (clr_sticky_i)                       sticky_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q    <= '0;
            sticky_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
        end else begin
            res_q    <= res_d;
            sticky_q <= sticky_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
        end
    end

    assign alu_out_o      = res_q.dat;
    assign alu_overflow_o = res_q.ovf;
    assign alu_illegal_o  = res_q.ill;
    assign ovf_sticky_o   = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: wrap/saturating 32-bit instances sharing stimulus, plus an 8-bit instance.
`timescale 1ns/1ps
module tb_alu_pipe;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOR  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b00110;
    localparam logic [4:0] OP_ROTR = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_NAND = 5'b01001;
    localparam logic [4:0] OP_MAX  = 5'b01010;
    localparam logic [4:0] OP_MIN  = 5'b01011;
    localparam logic [4:0] OP_ABS  = 5'b01100;
    localparam logic [4:0] OP_SLTS = 5'b01101;
    localparam logic [4:0] OP_SLL  = 5'b01110;
    localparam logic [4:0] OP_ROTL = 5'b01111;
    localparam logic [4:0] OP_ADDU = 5'b10000;
    localparam logic [4:0] OP_SRLU = 5'b10001;
    localparam logic [4:0] OP_MUL  = 5'b10010;
    localparam logic [4:0] OP_MULH = 5'b10011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, clr_sticky;
    logic [4:0]  alu_op;
    logic [31:0] src1, src2;
    logic        in_ready, out_valid, alu_ovf, alu_ill, sticky;
    logic [31:0] alu_out;
    logic        s_in_ready, s_out_valid, s_ovf, s_ill, s_sticky;
    logic [31:0] s_out;

    logic        d8_valid, d8_in_ready, d8_out_ready, d8_out_valid, d8_ovf, d8_ill, d8_sticky, d8_clr;
    logic [4:0]  d8_op;
    logic [7:0]  d8_a, d8_b, d8_out;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.DATA_W(32), .SAT_EN(1'b0)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .alu_op_i(alu_op), .src1_i(src1), .src2_i(src2), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .alu_out_o(alu_out), .alu_overflow_o(alu_ovf),
        .alu_illegal_o(alu_ill), .ovf_sticky_o(sticky), .clr_sticky_i(clr_sticky)
    );

    alu_pipe #(.DATA_W(32), .SAT_EN(1'b1)) u_sat (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .alu_op_i(alu_op), .src1_i(src1), .src2_i(src2), .out_valid_o(s_out_valid),
        .out_ready_i(out_ready), .alu_out_o(s_out), .alu_overflow_o(s_ovf),
        .alu_illegal_o(s_ill), .ovf_sticky_o(s_sticky), .clr_sticky_i(clr_sticky)
    );

    alu_pipe #(.DATA_W(8), .SAT_EN(1'b0)) u_d8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(d8_valid), .in_ready_o(d8_in_ready),
        .alu_op_i(d8_op), .src1_i(d8_a), .src2_i(d8_b), .out_valid_o(d8_out_valid),
        .out_ready_i(d8_out_ready), .alu_out_o(d8_out), .alu_overflow_o(d8_ovf),
        .alu_illegal_o(d8_ill), .ovf_sticky_o(d8_sticky), .clr_sticky_i(d8_clr)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic [31:0] exp_sat;
        logic        exp_ovf;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] eo, input logic [31:0] es, input logic ev,
                                input logic ei);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_out = eo; v.exp_sat = es; v.exp_ovf = ev; v.exp_ill = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Accepts a multiply with out_ready low, scrambles sources, and measures latency to out_valid.
    task automatic do_mul(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic exp_ovf, input string name);
        int cyc;
        int rdy_hi;
        alu_op = op; src1 = a; src2 = b; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; src1 = ~a; src2 = 32'h5;
        cyc = 1;
        rdy_hi = (!out_valid && in_ready) ? 1 : 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!out_valid && in_ready) rdy_hi++;
        end
        chk({name, " latency"}, cyc, 33);
        chk({name, " in_ready while busy"}, rdy_hi, 0);
        chk({name, " out"}, alu_out, exp_out);
        chk({name, " ovf"}, alu_ovf, exp_ovf);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int bad;
        logic [31:0] held;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        alu_op = '0; src1 = '0; src2 = '0;
        d8_valid = 1'b0; d8_out_ready = 1'b0; d8_clr = 1'b0; d8_op = '0; d8_a = '0; d8_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset alu_out", alu_out, 0);
        chk("reset ovf", alu_ovf, 0);
        chk("reset illegal", alu_ill, 0);
        chk("reset sticky", sticky, 0);

        // ADD overflow: wrap vs saturate, 1-cycle latency, sticky after transfer.
        alu_op = OP_ADD; src1 = 32'h7FFFFFFF; src2 = 32'h1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("add ovf valid", out_valid, 1);
        chk("add ovf wrap out", alu_out, 32'h80000000);
        chk("add ovf flag", alu_ovf, 1);
        chk("add sat out", s_out, 32'h7FFFFFFF);
        chk("add sat flag", s_ovf, 1);
        chk("sticky before take", sticky, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("sticky after take", sticky, 1);
        chk("idle after take", out_valid, 0);

        vecs.push_back(mk(OP_ADD,  32'h00000005, 32'hFFFFFFFD, 32'h00000002, 32'h00000002, 0, 0));
        vecs.push_back(mk(OP_ADD,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 1, 0));
        vecs.push_back(mk(OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 1, 0));
        vecs.push_back(mk(OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0));
        vecs.push_back(mk(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'hF000F000, 0, 0));
        vecs.push_back(mk(OP_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'hFFFFF0F0, 0, 0));
        vecs.push_back(mk(OP_XOR,  32'h12345678, 32'h0000FFFF, 32'h1234A987, 32'h1234A987, 0, 0));
        vecs.push_back(mk(OP_ROTL, 32'h80000001, 32'h00000001, 32'h00000003, 32'h00000003, 0, 0));
        vecs.push_back(mk(OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 32'hF8000000, 0, 0));
        vecs.push_back(mk(OP_ABS,  32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 1, 0));
        vecs.push_back(mk(OP_ABS,  32'hFFFFFFFB, 32'h00000000, 32'h00000005, 32'h00000005, 0, 0));
        vecs.push_back(mk(OP_NOR,  32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 32'hFF000000, 0, 0));
        vecs.push_back(mk(OP_NOT,  32'h0000FFFF, 32'h12345678, 32'hFFFF0000, 32'hFFFF0000, 0, 0));
        vecs.push_back(mk(OP_NAND, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFF0000, 0, 0));
        vecs.push_back(mk(OP_SRLU, 32'h80000000, 32'h00000004, 32'h08000000, 32'h08000000, 0, 0));
        vecs.push_back(mk(OP_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 32'h00000002, 0, 0));
        vecs.push_back(mk(OP_ROTR, 32'h12345678, 32'h00000000, 32'h12345678, 32'h12345678, 0, 0));
        vecs.push_back(mk(OP_ROTR, 32'h00000001, 32'h00000004, 32'h10000000, 32'h10000000, 0, 0));
        vecs.push_back(mk(OP_ROTL, 32'h12345678, 32'h00000020, 32'h12345678, 32'h12345678, 0, 0));
        vecs.push_back(mk(OP_MAX,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000001, 0, 0));
        vecs.push_back(mk(OP_MIN,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0));
        vecs.push_back(mk(OP_SLTS, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000001, 0, 0));
        vecs.push_back(mk(OP_SLTS, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 0, 0));
        vecs.push_back(mk(OP_ADDU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1, 0));
        vecs.push_back(mk(OP_ADDU, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000003, 0, 0));
        vecs.push_back(mk(5'b11111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h00000000, 0, 1));
        vecs.push_back(mk(5'b10100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 0, 1));

        // Back-to-back with out_ready high: one result per cycle.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            alu_op = vecs[i].op; src1 = vecs[i].a; src2 = vecs[i].b; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), out_valid, 1);
            chk($sformatf("vec%0d out", i), alu_out, vecs[i].exp_out);
            chk($sformatf("vec%0d ovf", i), alu_ovf, vecs[i].exp_ovf);
            chk($sformatf("vec%0d illegal", i), alu_ill, vecs[i].exp_ill);
            chk($sformatf("vec%0d sat out", i), s_out, vecs[i].exp_sat);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle after stream", out_valid, 0);

        do_mul(OP_MUL, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b0, "mul neg");
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        do_mul(OP_MULH, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0, "mulh");

        // Backpressure: hold the MULH result for 5 cycles, then a single-cycle pulse.
        held = alu_out;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (alu_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        chk("backpressure hold", bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("single pulse drains", out_valid, 0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("no extra result", cnt, 0);

        do_mul(OP_MUL, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, "mul ovf");
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        do_mul(OP_MUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "mul minneg");
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

        // Reset in the middle of a multiply drops it.
        alu_op = OP_MUL; src1 = 32'h00000007; src2 = 32'h00000009; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst mid-mul valid", out_valid, 0);
        chk("rst mid-mul ready", in_ready, 1);
        chk("rst mid-mul out", alu_out, 0);
        out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rst mid-mul no result", cnt, 0);

        // Sticky: set wins over clear on the transfer cycle, clear alone next cycle.
        out_ready = 1'b0;
        alu_op = OP_ADD; src1 = 32'h7FFFFFFF; src2 = 32'h1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("sticky pre valid", out_valid, 1);
        chk("sticky cleared by reset", sticky, 0);
        out_ready = 1'b1; clr_sticky = 1'b1;
        @(negedge clk);
        chk("sticky set beats clear", sticky, 1);
        out_ready = 1'b0;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky clear alone", sticky, 0);

        // DATA_W = 8 instance.
        d8_out_ready = 1'b1;
        d8_op = OP_ROTR; d8_a = 8'h81; d8_b = 8'h09; d8_valid = 1'b1;
        @(negedge clk);
        chk("d8 rotr valid", d8_out_valid, 1);
        chk("d8 rotr out", d8_out, 8'hC0);
        d8_op = OP_ADD; d8_a = 8'h7F; d8_b = 8'h01;
        @(negedge clk);
        d8_valid = 1'b0;
        chk("d8 add out", d8_out, 8'h80);
        chk("d8 add ovf", d8_ovf, 1);
        @(negedge clk);
        d8_out_ready = 1'b0;
        d8_op = OP_MUL; d8_a = 8'hFE; d8_b = 8'h03; d8_valid = 1'b1;
        @(negedge clk);
        d8_valid = 1'b0;
        cnt = 1;
        while (!d8_out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("d8 mul latency", cnt, 9);
        chk("d8 mul out", d8_out, 8'hFA);
        chk("d8 mul ovf", d8_ovf, 0);
        d8_out_ready = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
